q_serializer: RTL and testbench

- Synthesizable transmitter for the serialized-Q link: converts a binary charge value into the pulse train carried on q_serialized.
- Each pulse represents Q_PER_PULSE charge units. A frame ends with an idle gap longer than the receiver watchdog window, so the on-chip Q measurement path reports the value.
- Replaces the behavioural resonant-system emulation as the stimulus source for silicon loopback and for FPGA bring-up.

---
 rtl/q_serializer_pkg.sv | 26 ++
 rtl/q_serializer_if.sv | 20 ++
 rtl/q_serializer_timer.sv | 36 +++
 rtl/q_serializer.sv | 147 ++++++++++++++
 tb/tb_q_serializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/q_serializer_pkg.sv
// -----------------------------------------------------------------------------
// q_link_pkg
// Shared definitions for the serialized-Q transmitter: FSM state encoding,
// default link parameters and a constant helper used to size the timer.
// -----------------------------------------------------------------------------
package q_link_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PULSE_HI  = 2'd1,
      PULSE_LO  = 2'd2,
      FRAME_GAP = 2'd3
   } q_state_e;

   localparam int BUS_WIDTH_DEF     = 10;
   localparam int Q_PER_PULSE_DEF   = 3;
   localparam int WTD_BUS_WIDTH_DEF = 3;

   // Largest of three durations; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/q_serializer_if.sv
// -----------------------------------------------------------------------------
// q_serializer_if
// Value handshake into the serializer.
//   enable  : source permits new frames
//   q_valid : q_in holds a value to send
//   q_in    : charge value
//   q_ready : transmitter can take a value this cycle
// master = value source, slave = q_serializer.
// -----------------------------------------------------------------------------
interface q_serializer_if #(
   parameter int BUS_WIDTH = q_link_pkg::BUS_WIDTH_DEF
);
   logic                 enable;
   logic                 q_valid;
   logic [BUS_WIDTH-1:0] q_in;
   logic                 q_ready;

   modport master (output enable, q_valid, q_in, input q_ready);
   modport slave  (input enable, q_valid, q_in, output q_ready);
endinterface

// File: rtl/q_serializer_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
// Loadable down-counter shared by all timed FSM states. Loading N-1 on state
// entry gives a dwell of exactly N cycles, with expired high on the last one.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_value this edge (takes priority over counting)
//   load_value : count to start from
//   expired    : counter is at zero
// -----------------------------------------------------------------------------
module pulse_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/q_serializer.sv
// -----------------------------------------------------------------------------
// q_serializer
// Converts a charge value into a pulse train on q_serialized: one pulse per
// Q_PER_PULSE units (remainder dropped), then an idle gap longer than the
// receiver watchdog window to close the frame.
//   clk, rst     : clock, asynchronous active-high reset
//   q_bus        : value handshake (slave side)
//   q_serialized : registered pulse line
//   busy         : frame in progress
//   frame_done   : strobe on the last idle cycle of a frame
//   pulse_count  : pulses emitted in the current/last frame
// -----------------------------------------------------------------------------
module q_serializer
   import q_link_pkg::*;
#(
   parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
   parameter int Q_PER_PULSE    = Q_PER_PULSE_DEF,
   parameter int PULSE_DURATION = 3,
   parameter int GAP_DURATION   = 2,
   parameter int WTD_BUS_WIDTH  = WTD_BUS_WIDTH_DEF,
   parameter int IDLE_CYCLES    = 2**WTD_BUS_WIDTH + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   q_serializer_if.slave        q_bus,
   output logic                 q_serialized,
   output logic                 busy,
   output logic                 frame_done,
   output logic [BUS_WIDTH-1:0] pulse_count
);

   if (IDLE_CYCLES <= 2**WTD_BUS_WIDTH || IDLE_CYCLES <= GAP_DURATION) begin : g_bad_idle
      $error("IDLE_CYCLES must exceed 2**WTD_BUS_WIDTH and GAP_DURATION");
   end
   if (Q_PER_PULSE < 1 || PULSE_DURATION < 1 || GAP_DURATION < 1) begin : g_bad_dur
      $error("Q_PER_PULSE, PULSE_DURATION and GAP_DURATION must be >= 1");
   end

   localparam int CNT_W = $clog2(max3(PULSE_DURATION, GAP_DURATION, IDLE_CYCLES) + 1);
   localparam logic [BUS_WIDTH-1:0] QPP     = BUS_WIDTH'(Q_PER_PULSE);
   localparam logic [CNT_W-1:0]     LD_HI   = CNT_W'(PULSE_DURATION - 1);
   localparam logic [CNT_W-1:0]     LD_LO   = CNT_W'(GAP_DURATION - 1);
   localparam logic [CNT_W-1:0]     LD_GAP  = CNT_W'(IDLE_CYCLES - 1);

   q_state_e             state_q, state_d;
   logic [BUS_WIDTH-1:0] remaining_q, remaining_d;
   logic [BUS_WIDTH-1:0] pulse_count_q, pulse_count_d;
   logic                 busy_q, busy_d;
   logic                 ser_q;
   logic                 tmr_load;
   logic [CNT_W-1:0]     tmr_value;
   logic                 tmr_expired;
   logic                 q_ready;

   pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .expired    (tmr_expired)
   );

   assign q_ready       = (state_q == IDLE) && q_bus.enable;
   assign q_bus.q_ready = q_ready;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      pulse_count_d = pulse_count_q;
      busy_d        = busy_q;
      tmr_load      = 1'b0;
      tmr_value     = '0;

      unique case (state_q)
         IDLE: begin
            if (q_bus.q_valid && q_ready) begin
               remaining_d   = q_bus.q_in;
               pulse_count_d = '0;
               busy_d        = 1'b1;
               tmr_load      = 1'b1;
               if (q_bus.q_in >= QPP) begin
                  state_d   = PULSE_HI;
                  tmr_value = LD_HI;
               end else begin
                  state_d   = FRAME_GAP;
                  tmr_value = LD_GAP;
               end
            end
         end
         PULSE_HI: begin
            if (tmr_expired) begin
               // Only entered with remaining >= QPP, so this cannot underflow.
               remaining_d   = remaining_q - QPP;
               pulse_count_d = pulse_count_q + BUS_WIDTH'(1);
               tmr_load      = 1'b1;
               if (remaining_d >= QPP) begin
                  state_d   = PULSE_LO;
                  tmr_value = LD_LO;
               end else begin
                  state_d   = FRAME_GAP;
                  tmr_value = LD_GAP;
               end
            end
         end
         PULSE_LO: begin
            if (tmr_expired) begin
               state_d   = PULSE_HI;
               tmr_load  = 1'b1;
               tmr_value = LD_HI;
            end
         end
         FRAME_GAP: begin
            if (tmr_expired) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         remaining_q   <= '0;
         pulse_count_q <= '0;
         busy_q        <= 1'b0;
         ser_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         pulse_count_q <= pulse_count_d;
         busy_q        <= busy_d;
         // Line register follows the next state so the pulse starts the cycle
         // right after the deciding edge, with no combinational glitches.
         ser_q         <= (state_d == PULSE_HI);
      end
   end

   assign q_serialized = ser_q;
   assign busy         = busy_q;
   assign pulse_count  = pulse_count_q;
   assign frame_done   = (state_q == FRAME_GAP) && tmr_expired;

endmodule

// File: tb/tb_q_serializer.sv
// -----------------------------------------------------------------------------
// tb_q_serializer
// Directed bench for q_serializer at default parameters. A negedge monitor
// acts as the receiver: it models the ready/accept rule, pushes the expected
// pulse count per accepted value and checks pulse shape, frame length and
// final counts when frame_done arrives.
// -----------------------------------------------------------------------------
module tb_q_serializer;
   import q_link_pkg::*;

   localparam int BW   = 10;
   localparam int QPP  = 3;
   localparam int HI   = 3;
   localparam int LO   = 2;
   localparam int IDLE = 10;

   typedef struct {
      int n;
      int q;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          q_serialized, busy, frame_done;
   logic [BW-1:0] pulse_count;

   q_serializer_if #(.BUS_WIDTH(BW)) q_bus ();

   q_serializer #(.BUS_WIDTH(BW)) dut (
      .clk          (clk),
      .rst          (rst),
      .q_bus        (q_bus.slave),
      .q_serialized (q_serialized),
      .busy         (busy),
      .frame_done   (frame_done),
      .pulse_count  (pulse_count)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- receiver / scoreboard monitor ----------------
   bit   model_idle = 1'b1;
   bit   in_frame   = 1'b0;
   bit   first_cyc  = 1'b0;
   bit   prev_ser   = 1'b0;
   int   hi_run, lo_run, pulses, frame_cyc;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         model_idle = 1'b1;
         in_frame   = 1'b0;
         prev_ser   = 1'b0;
         check("rst_frame_done", frame_done, 0);
      end else begin
         bit   acc;
         exp_t e;
         acc = q_bus.q_valid && q_bus.enable && model_idle;
         check("q_ready", q_bus.q_ready, q_bus.enable && model_idle);
         check("busy", busy, in_frame);
         if (in_frame) begin
            frame_cyc++;
            if (first_cyc) begin
               check("first_rise", q_serialized, sb[0].n > 0);
               first_cyc = 1'b0;
            end
            if (q_serialized) begin
               if (!prev_ser) begin
                  if (pulses > 0) check("gap_len", lo_run, LO);
                  hi_run = 0;
               end
               hi_run++;
            end else begin
               if (prev_ser) begin
                  check("pulse_len", hi_run, HI);
                  pulses++;
                  lo_run = 0;
               end
               lo_run++;
            end
            if (frame_done) begin
               check("sb_occupancy", sb.size(), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("pulses", pulses, e.n);
                  check("pulse_count", pulse_count, e.n);
                  check("q_measured", pulses * QPP, e.q);
                  check("frame_len", frame_cyc,
                        (e.n > 0) ? e.n * HI + (e.n - 1) * LO + IDLE : IDLE);
                  if (e.n > 0) check("tail_gap", lo_run, IDLE);
               end
               in_frame   = 1'b0;
               model_idle = 1'b1;
            end
         end else begin
            check("stray_frame_done", frame_done, 0);
         end
         prev_ser = q_serialized;
         if (acc) begin
            e.n = int'(q_bus.q_in) / QPP;
            e.q = int'(q_bus.q_in) - (int'(q_bus.q_in) % QPP);
            sb.push_back(e);
            in_frame   = 1'b1;
            first_cyc  = 1'b1;
            model_idle = 1'b0;
            frame_cyc  = 0;
            pulses     = 0;
            hi_run     = 0;
            lo_run     = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int v);
      @(posedge clk); #1;
      q_bus.q_in    = BW'(v);
      q_bus.q_valid = 1'b1;
      @(posedge clk); #1;
      q_bus.q_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      check({tag, "_timeout"}, seen, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------- directed sequence ----------------
   initial begin
      q_bus.enable  = 1'b0;
      q_bus.q_valid = 1'b0;
      q_bus.q_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ser", q_serialized, 0);
      check("rst_busy", busy, 0);
      check("rst_pcount", pulse_count, 0);
      check("rst_ready", q_bus.q_ready, 0);
      rst = 1'b0;
      q_bus.enable = 1'b1;

      // Three pulses, then zero-pulse and full-scale frames.
      send(10);
      wait_done("f10", 200);
      send(2);
      wait_done("f2", 200);
      send(1023);
      wait_done("f1023", 3000);
      check("hold_pcount", pulse_count, 341);

      // Back-to-back with q_valid held and q_in toggling during frame 1.
      @(posedge clk); #1;
      q_bus.q_in    = BW'(30);
      q_bus.q_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         q_bus.q_in = (i % 2 == 0) ? BW'(5) : BW'(60);
         @(posedge clk); #1;
      end
      q_bus.q_in = BW'(60);
      wait_done("b2b_1", 200);
      @(posedge clk); #1;
      check("b2b_accept", busy, 1);
      q_bus.q_valid = 1'b0;
      wait_done("b2b_2", 400);

      // Async reset during the 2nd cycle of the 2nd pulse.
      send(30);
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_ser", q_serialized, 1);
      #1;
      rst = 1'b1;
      #1;
      check("async_ser", q_serialized, 0);
      check("async_busy", busy, 0);
      check("async_pcount", pulse_count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send(6);
      wait_done("post_rst", 200);

      // enable dropped mid-frame: frame still completes, no new accept.
      send(15);
      repeat (4) @(posedge clk);
      #1;
      q_bus.enable  = 1'b0;
      q_bus.q_valid = 1'b1;
      q_bus.q_in    = BW'(9);
      wait_done("en_drop", 200);
      repeat (3) @(posedge clk);
      #1;
      check("ready_blocked", q_bus.q_ready, 0);
      check("still_idle", busy, 0);
      q_bus.q_valid = 1'b0;
      q_bus.enable  = 1'b1;
      @(posedge clk); #1;
      check("ready_back", q_bus.q_ready, 1);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
